alu_ctrl_seq: RTL
=================

// Module: alu_ctrl_seq
// PURPOSE
//  Multi-cycle fetch/decode/execute sequencer that drives the ALU control fields and consumes its results.
//  Fetches 32-bit instructions over a req/ack port and decodes cond/opcode/sbit/srcontrol/imvalue for the ALU.
//  Reads operands from a 16x32 register file, holds the NZCV flag register, performs writeback and LDR/STR data-memory access.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  PC_STEP   4              PC increment per instruction (byte addressing)
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   synchronous, active-high reset
//  imem_req      out  1   instruction fetch request
//  imem_addr     out  32  fetch address (=pc)
//  imem_ack      in   1   fetch data valid / request accepted
//  imem_rdata    in   32  instruction word
//  dmem_req      out  1   data access request
//  dmem_we       out  1   1=store, 0=load
//  dmem_addr     out  32  R[rn] + zext(ir[7:0])
//  dmem_wdata    out  32  R[rd] (store data)
//  dmem_ack      in   1   data access complete
//  dmem_rdata    in   32  load data
//  alu_in1/alu_in2 out 32 R[rn] / R[rm] operand latches
//  alu_cond/alu_opcode out 4 ir[31:28] / ir[27:24]
//  alu_sbit      out  1   ir[23]
//  alu_srcontrol out  3   ir[22:20]
//  alu_imvalue   out  16  ir[15:0]
//  alu_inflags   out  4   flag register {N,Z,C,V}
//  alu_outflags  in   4   ALU flag result
//  alu_result    in   32  ALU result
//  pc            out  32  current PC
//  illegal_op    out  1   one-cycle pulse: opcode 1011..1110 executed
// BEHAVIOUR
//  Instr fields: cond[31:28] op[27:24] s[23] sr[22:20] rd[19:16] rn[15:12] rm[11:8] imm[15:0].
//  Reset: state=IDLE, pc=RESET_PC, ir=0, flags=4'b0000, all regs=0, all req/we/illegal_op=0, alu_* outputs=0.
//  Reset mid-operation: outstanding req dropped at that edge, no writeback; late ack after reset ignored.
//  FSM: IDLE->FETCH (1 cycle).
//   FETCH: imem_req=1, addr=pc stable; on ack: ir<=imem_rdata -> DECODE. Ack in first FETCH cycle accepted.
//   DECODE: latch R[rn],R[rm],R[rd] into operand regs -> EXECUTE.
//   EXECUTE: alu_* stable; cond_met = cond_check(cond, flags) (same table as ALU: 0001 EQ..1000 HS, else always).
//    cond_met & op 0000..0111: R[rd]<=alu_result; pc+=PC_STEP -> FETCH.
//    cond_met & (sbit | op==1000 CMP): flags<=alu_outflags same edge.
//    cond_met & op 1001/1010: -> MEM (pc unchanged until MEM completes).
//    !cond_met, op 1111, op 1011..1110: no write, no flag update, pc+=PC_STEP -> FETCH; illegal pulse if 1011..1110 & cond_met.
//   MEM: dmem_req=1, addr/wdata/we stable until ack; on ack: LDR R[rd]<=dmem_rdata; pc+=PC_STEP -> FETCH.
//  Handshake: req held until ack sampled high; ack while req low ignored; one access outstanding max.
//  Latency: ALU op 3 cycles (0-wait fetch); LDR/STR 4 cycles + waits.
//  PC wraps modulo 2^32 (FFFF_FFFC+4=0). Address add truncated to 32 bits.
//  rd==rn/rm: operands latched in DECODE, so writeback never affects the same instruction.
//  Flag write and register write in same EXECUTE edge both occur; next instruction sees both.
// STRUCTURE
//  alu_ctrl_pkg: opcode constants (ADD..STR, NOP=4'b1111), cond codes, FSM state encoding,
//   function cond_check(cond, flags). Shared with ALU to keep condition table single-sourced.
//  Sub-module reg_file_16x32: 3 async read ports (rn,rm,rd), 1 sync write port, sync reset to 0.
// TESTING
//  Reset then 0-wait imem: MOVN R1,#0x1234 -> R1=0x0000_1234 after 3 cycles, pc=4.
//  R1=5,R2=5: SUBS-free CMP R1,R2 then ADD.EQ R3,R1,R2 -> flags Z=1, R3=10; ADD.NE variant leaves R3=0.
//  STR R1,[R4,#8] with R4=0x100, dmem_ack after 3 waits -> addr 0x108, wdata=R1, req held 4 cycles.
//  LDR R5,[R4,#0] rdata=0xDEAD_BEEF -> R5=0xDEAD_BEEF; reset during MEM -> R5 stays 0, pc=0, req=0 next cycle.
//  pc=FFFF_FFFC, NOP -> pc=0; opcode 1100 -> illegal_op pulse 1 cycle, no register/flag change.
//  imem_ack held low 10 cycles -> imem_req, imem_addr stable, no state advance; stray dmem_ack ignored.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared opcode/condition definitions for the ALU sequencer and the ALU itself.
// Keeps the condition table single-sourced between the two blocks.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_ORR  = 4'h3,
    OP_EOR  = 4'h4, OP_MOV  = 4'h5, OP_MOVN = 4'h6, OP_ADDI = 4'h7,
    OP_CMP  = 4'h8, OP_LDR  = 4'h9, OP_STR  = 4'hA, OP_ILL0 = 4'hB,
    OP_ILL1 = 4'hC, OP_ILL2 = 4'hD, OP_ILL3 = 4'hE, OP_NOP  = 4'hF
  } opcode_t;

  typedef enum logic [3:0] {
    CC_AL = 4'h0, CC_EQ = 4'h1, CC_NE = 4'h2, CC_MI = 4'h3, CC_PL = 4'h4,
    CC_VS = 4'h5, CC_VC = 4'h6, CC_LO = 4'h7, CC_HS = 4'h8
  } cond_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM
  } state_t;

  // flags = {N,Z,C,V}; codes outside 0001..1000 mean "always"
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      CC_EQ:   return z;
      CC_NE:   return !z;
      CC_MI:   return n;
      CC_PL:   return !n;
      CC_VS:   return v;
      CC_VC:   return !v;
      CC_LO:   return !c;
      CC_HS:   return c;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/reg_file_16x32.sv
// 16x32 register file: three asynchronous read ports, one synchronous write port.
module reg_file_16x32 (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_we,
  input  logic [3:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_ra_a,
  input  logic [3:0]  i_ra_b,
  input  logic [3:0]  i_ra_c,
  output logic [31:0] o_rd_a,
  output logic [31:0] o_rd_b,
  output logic [31:0] o_rd_c
);

  logic [31:0] r_mem [16];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rd_a = r_mem[i_ra_a];
  assign o_rd_b = r_mem[i_ra_b];
  assign o_rd_c = r_mem[i_ra_c];

endmodule

// File: rtl/alu_ctrl_seq.sv
// Fetch/decode/execute sequencer driving an external ALU, with NZCV flags and LDR/STR access.
// state | meaning: IDLE post-reset | FETCH imem req until ack | DECODE latch operands | EXEC writeback/flags | MEM dmem req until ack
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic [31:0] o_alu_in1,
  output logic [31:0] o_alu_in2,
  output logic [3:0]  o_alu_cond,
  output logic [3:0]  o_alu_opcode,
  output logic        o_alu_sbit,
  output logic [2:0]  o_alu_srcontrol,
  output logic [15:0] o_alu_imvalue,
  output logic [3:0]  o_alu_inflags,
  input  logic [3:0]  i_alu_outflags,
  input  logic [31:0] i_alu_result,
  output logic [31:0] o_pc,
  output logic        o_illegal_op
);

  state_t      r_state, w_next_state;
  logic [31:0] r_pc, r_ir, r_op_a, r_op_b, r_op_d;
  logic [3:0]  r_flags;
  logic [31:0] w_rf_a, w_rf_b, w_rf_d, w_rf_wdata;
  logic [3:0]  w_op;
  logic        w_cond_met, w_rf_we, w_flag_we, w_pc_adv, w_is_mem;

  assign w_op       = r_ir[27:24];
  assign w_cond_met = cond_check(r_ir[31:28], r_flags);
  assign w_is_mem   = (w_op == OP_LDR) || (w_op == OP_STR);

  reg_file_16x32 u_rf (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (w_rf_we),
    .i_waddr (r_ir[19:16]),
    .i_wdata (w_rf_wdata),
    .i_ra_a  (r_ir[15:12]),
    .i_ra_b  (r_ir[11:8]),
    .i_ra_c  (r_ir[19:16]),
    .o_rd_a  (w_rf_a),
    .o_rd_b  (w_rf_b),
    .o_rd_c  (w_rf_d)
  );

  always_comb begin
    w_next_state = r_state;
    w_pc_adv     = 1'b0;
    w_rf_we      = 1'b0;
    w_rf_wdata   = i_alu_result;
    w_flag_we    = 1'b0;
    o_imem_req   = 1'b0;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_illegal_op = 1'b0;
    case (r_state)
      ST_IDLE:   w_next_state = ST_FETCH;
      ST_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) w_next_state = ST_DECODE;
      end
      ST_DECODE: w_next_state = ST_EXEC;
      ST_EXEC: begin
        w_next_state = ST_FETCH;
        w_pc_adv     = 1'b1;
        if (w_cond_met) begin
          w_rf_we      = (w_op <= OP_ADDI);
          w_flag_we    = (w_op <= OP_CMP) && (r_ir[23] || (w_op == OP_CMP));
          o_illegal_op = (w_op >= OP_ILL0) && (w_op <= OP_ILL3);
          if (w_is_mem) begin
            w_next_state = ST_MEM;
            w_pc_adv     = 1'b0;
          end
        end
      end
      ST_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = (w_op == OP_STR);
        if (i_dmem_ack) begin
          w_next_state = ST_FETCH;
          w_pc_adv     = 1'b1;
          w_rf_we      = (w_op == OP_LDR);
          w_rf_wdata   = i_dmem_rdata;
        end
      end
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_flags <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_op_d  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_FETCH && i_imem_ack) r_ir <= i_imem_rdata;
      // operands captured here so a same-register writeback in EXEC cannot leak in
      if (r_state == ST_DECODE) begin
        r_op_a <= w_rf_a;
        r_op_b <= w_rf_b;
        r_op_d <= w_rf_d;
      end
      if (w_pc_adv)  r_pc    <= r_pc + PC_STEP;
      if (w_flag_we) r_flags <= i_alu_outflags;
    end
  end

  assign o_imem_addr     = r_pc;
  assign o_pc            = r_pc;
  assign o_dmem_addr     = r_op_a + {24'h0, r_ir[7:0]};
  assign o_dmem_wdata    = r_op_d;
  assign o_alu_in1       = r_op_a;
  assign o_alu_in2       = r_op_b;
  assign o_alu_cond      = r_ir[31:28];
  assign o_alu_opcode    = r_ir[27:24];
  assign o_alu_sbit      = r_ir[23];
  assign o_alu_srcontrol = r_ir[22:20];
  assign o_alu_imvalue   = r_ir[15:0];
  assign o_alu_inflags   = r_flags;

endmodule
